// File: rtl/reg_cmd_sequencer_pkg.sv
// rtl/reg_cmd_sequencer_pkg.sv - shared op codes, state encodings and strobe layout for the command sequencer
//
// Purpose: common definitions imported by reg_cmd_sequencer and reg_cmd_decode.
// Ports: none (package).
package reg_cmd_sequencer_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 2;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ROT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside the one-hot strobe vector {cl, ld, inc, dec, sr, sl}.
    localparam int NSTB   = 6;
    localparam int STB_CL = 5;
    localparam int STB_LD = 4;
    localparam int STB_IN = 3;
    localparam int STB_DE = 2;
    localparam int STB_SR = 1;
    localparam int STB_SL = 0;

    // Where the serial-in bit (ir/il) comes from.
    typedef enum logic [1:0] {
        SER_NONE = 2'd0,
        SER_FILL = 2'd1,
        SER_ROT  = 2'd2
    } ser_src_e;

    // CLR and LOAD always take a single step regardless of cmd_cnt.
    function automatic logic op_is_single(input logic [2:0] op);
        return (op == OP_CLR) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/reg_cmd_sequencer_decode.sv
// rtl/reg_cmd_sequencer_decode.sv - combinational op to one-hot strobe and serial source decode
//
// Purpose: maps a command op (and rotate direction) to the register strobe it drives.
// Ports:
//   op_i      command op code
//   fill_i    fill bit / rotate direction (0 right, 1 left)
//   strobe_o  one-hot {cl, ld, inc, dec, sr, sl}; all zero for NOP
//   ser_src_o source of ir/il for this op
module reg_cmd_decode
    import reg_cmd_sequencer_pkg::*;
(
    input  logic [2:0]      op_i,
    input  logic            fill_i,
    output logic [NSTB-1:0] strobe_o,
    output ser_src_e        ser_src_o
);

    always_comb begin
        strobe_o  = '0;
        ser_src_o = SER_NONE;
        case (op_i)
            OP_CLR:  strobe_o[STB_CL] = 1'b1;
            OP_LOAD: strobe_o[STB_LD] = 1'b1;
            OP_INC:  strobe_o[STB_IN] = 1'b1;
            OP_DEC:  strobe_o[STB_DE] = 1'b1;
            OP_SHR: begin
                strobe_o[STB_SR] = 1'b1;
                ser_src_o        = SER_FILL;
            end
            OP_SHL: begin
                strobe_o[STB_SL] = 1'b1;
                ser_src_o        = SER_FILL;
            end
            OP_ROT: begin
                // Rotate is a shift whose serial-in is the bit falling off the other end.
                if (fill_i) strobe_o[STB_SL] = 1'b1;
                else        strobe_o[STB_SR] = 1'b1;
                ser_src_o = SER_ROT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_cmd_sequencer.sv
// rtl/reg_cmd_sequencer.sv - command sequencer expanding ops into timed register control strobes
//
// Purpose: accepts one command over valid/ready and drives the 4-bit shift/count register.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/cmd_cnt/cmd_data/cmd_fill  command fields
//   reg_out                       register contents fed back (rotate)
//   cl, ld, inc, dec, sr, sl      one-hot register strobes
//   ir, il, in                    register serial-in bits and parallel data
//   busy, done                    status; done is a one-cycle pulse
module reg_cmd_sequencer
    import reg_cmd_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_fill,
    input  logic [DATA_W-1:0] reg_out,
    output logic              cl,
    output logic              ld,
    output logic              inc,
    output logic              dec,
    output logic              sr,
    output logic              sl,
    output logic              ir,
    output logic              il,
    output logic [DATA_W-1:0] in,
    output logic              busy,
    output logic              done
);

    localparam int STEP_W = CNT_W + 1;

    state_e             state_q;
    logic [STEP_W-1:0]  steps_q;
    logic [STEP_W-1:0]  steps_d;
    logic [STEP_W-1:0]  accept_steps;
    logic [NSTB-1:0]    stb_q;
    logic [DATA_W-1:0]  in_q;
    logic               ir_q;
    logic               il_q;
    logic               rot_q;
    logic               done_q;

    logic [NSTB-1:0]    dec_stb;
    ser_src_e           dec_src;

    reg_cmd_decode u_decode (
        .op_i      (cmd_op),
        .fill_i    (cmd_fill),
        .strobe_o  (dec_stb),
        .ser_src_o (dec_src)
    );

    always_comb begin
        steps_d      = steps_q - STEP_W'(1);
        accept_steps = op_is_single(cmd_op) ? STEP_W'(1)
                                            : STEP_W'({1'b0, cmd_cnt}) + STEP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            steps_q <= '0;
            stb_q   <= '0;
            in_q    <= '0;
            ir_q    <= 1'b0;
            il_q    <= 1'b0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_op == OP_NOP) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            // The first step's strobes are registered here so they are
                            // already high in the cycle after the accepting edge.
                            state_q <= ST_EXEC;
                            steps_q <= accept_steps;
                            stb_q   <= dec_stb;
                            in_q    <= (cmd_op == OP_LOAD) ? cmd_data : '0;
                            ir_q    <= (dec_src == SER_FILL) & dec_stb[STB_SR] & cmd_fill;
                            il_q    <= (dec_src == SER_FILL) & dec_stb[STB_SL] & cmd_fill;
                            rot_q   <= (dec_src == SER_ROT);
                        end
                    end
                end
                ST_EXEC: begin
                    if (steps_q == STEP_W'(1)) begin
                        state_q <= ST_DONE;
                        steps_q <= '0;
                        stb_q   <= '0;
                        in_q    <= '0;
                        ir_q    <= 1'b0;
                        il_q    <= 1'b0;
                        rot_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        steps_q <= steps_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cl   = stb_q[STB_CL];
    assign ld   = stb_q[STB_LD];
    assign inc  = stb_q[STB_IN];
    assign dec  = stb_q[STB_DE];
    assign sr   = stb_q[STB_SR];
    assign sl   = stb_q[STB_SL];
    assign in   = in_q;
    // Rotate feeds back the live register value so each step sees the previous step's result.
    assign ir   = rot_q ? (stb_q[STB_SR] & reg_out[0])        : ir_q;
    assign il   = rot_q ? (stb_q[STB_SL] & reg_out[DATA_W-1]) : il_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign cmd_ready = (state_q == ST_IDLE);

endmodule

// File: doc/reg_cmd_sequencer.md
Name: reg_cmd_sequencer

Overview:
Command-driven control stage directly upstream of the 4-bit shift/count register.
- Accepts one command at a time over a valid/ready handshake.
- Expands each command into a timed sequence of one-hot register control strobes (cl, ld, inc, dec, sr, ir, sl, il, in), repeating the strobe for multi-step operations.
- Reads the register's `out` back so it can implement rotate, which the register has no native support for.

Parameters:
- DATA_W, 4, width of cmd_data, in, reg_out
- CNT_W, 2, width of cmd_cnt; repeat count = cmd_cnt+1 (1..4 steps)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  3  0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 ROT
- cmd_cnt  input  CNT_W  repeat count minus one; used by ops 3..7 only
- cmd_data  input  DATA_W  load value for LOAD
- cmd_fill  input  1  serial fill bit for SHR/SHL; rotate direction for ROT (0 right, 1 left)
- reg_out  input  DATA_W  current register contents, fed back
- cl, ld, inc, dec, sr, sl  output  1  register control strobes
- ir, il  output  1  register serial-in bits
- in  output  DATA_W  register parallel data
- busy  output  1  high in EXEC or DONE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, step counter=0, latched command=0.
  - All strobes, ir, il, in, busy and done are 0.
  - cmd_ready=1, but nothing is accepted until rst_n=1.
- States:
  - IDLE: cmd_ready=1. On `cmd_valid & cmd_ready` at an edge, latch op/cnt/data/fill.
    - NOP goes to DONE.
    - Every other op goes to EXEC with steps = (CLR/LOAD ? 1 : cmd_cnt+1).
  - EXEC: cmd_ready=0, busy=1. Exactly one strobe is high per cycle:
    - CLR: cl.
    - LOAD: ld with in=data.
    - INC: inc.
    - DEC: dec.
    - SHR: sr with ir=fill.
    - SHL: sl with il=fill.
    - ROT right: sr with ir=reg_out[0].
    - ROT left: sl with il=reg_out[DATA_W-1].
    - The step counter decrements at each edge; after the last step the state goes to DONE.
  - DONE: done=1, busy=1, all strobes 0. Next state is IDLE.
- Latency:
  - Command accepted at edge k.
  - Strobes are high in cycles k+1..k+N; the register samples them at edges k+1..k+N.
  - done is high in cycle k+N+1.
  - cmd_ready returns at k+N+2, so the next accept is possible at edge k+N+2.
  - NOP: done in cycle k+1.
- Output timing:
  - Strobes, `in`, and the fill-based ir/il are registered.
  - For ROT, ir/il are combinational from reg_out, so every rotate step uses the value updated by the previous step.
- Idle and non-shift outputs:
  - `in` is 0 except during LOAD.
  - ir/il are 0 except during SHR/SHL/ROT.
- Strobe priority: never more than one strobe at a time, so register priority never matters.
- Commands in flight: cmd_valid while not ready is ignored and the command is held by the producer. Fields are latched, so input changes during EXEC have no effect.
- Reset mid-EXEC: strobes drop immediately (asynchronously), no done is issued, and the command is lost.
- Wrap-around: repeated INC/DEC wrap modulo 2^DATA_W inside the register; the sequencer does not saturate.

Decomposition:
- Shared package holds:
  - op codes OP_NOP..OP_ROT as 3-bit localparams.
  - state encodings ST_IDLE, ST_EXEC, ST_DONE.
  - DATA_W default.
- Optional sub-module reg_cmd_decode: combinational op -> one-hot strobe vector plus the source select for ir/il. The sequencer FSM and step counter remain in reg_cmd_sequencer.
- Bench instantiates reg_cmd_sequencer driving the existing register, with reg_out tied back.

Test Plan:
- Reset, then LOAD data=4'b1010: ld high exactly one cycle with in=1010, reg out=1010, done pulse 2 cycles after accept, cmd_ready back next cycle.
- From out=1110, INC cnt=3: inc high 4 consecutive cycles, out=0010 (wrap through 1111/0000), single done.
- From out=1001, ROT right cnt=1: out 1100 then 0110. ROT left cnt=0 from 0110: out=1100.
- SHL cnt=2 fill=1 from 0000: out 0001, 0011, 0111. SHR cnt=0 fill=0 from 0111: out 0011.
- Hold cmd_valid=1 with back-to-back CLR then DEC cnt=0: CLR accepted, second command accepted only when cmd_ready returns, out 0000 then 1111. NOP gives done one cycle after accept with no strobes.
- Assert rst_n=0 mid-way through INC cnt=3 (after 2 steps): strobes drop immediately, no done, state IDLE. After release, a LOAD 0101 executes normally.
